a2d_rr_sampler: RTL and testbench

//  Upstream feeder of the steering-enable SM. Sequences a SPI master through round-robin
//  A2D conversions and holds the latest 12-bit results: lft_ld, rght_ld, steer_pot, batt.

---
 rtl/a2d_rr_sampler.sv | 164 ++++++++++++++++
 tb/tb_a2d_rr_sampler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/a2d_rr_sampler.sv
// Round-robin A2D sampler: each nxt runs one convert + readback SPI pair on the
// next channel (lft, rght, steer, batt) and latches the 12-bit result.
module a2d_rr_sampler #(
  parameter logic [2:0] CH_LFT   = 3'd0,
  parameter logic [2:0] CH_RGHT  = 3'd4,
  parameter logic [2:0] CH_STEER = 3'd5,
  parameter logic [2:0] CH_BATT  = 3'd6,
  parameter int         GAP_CYC  = 4,
  parameter int         TMO_CYC  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        busy,
  output logic        ld_vld,
  output logic        err
);

  localparam int TW = $clog2(TMO_CYC);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  typedef enum logic [2:0] {IDLE, CNV, GAP, RD, STORE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        gap_q, gap_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [11:0]       data_q, data_d;
  logic [3:0][11:0]  res_q, res_d;
  logic              wrt_q, wrt_d;
  logic [15:0]       cmd_q, cmd_d;
  logic              busy_q, busy_d;
  logic              ld_vld_q, ld_vld_d;
  logic              err_q, err_d;
  logic [2:0]        ch_sel;
  logic              unused_hi;

  assign unused_hi = ^rd_data[15:12];

  always_comb begin
    ch_sel = CH_LFT;
    case (ptr_q)
      2'd0:    ch_sel = CH_LFT;
      2'd1:    ch_sel = CH_RGHT;
      2'd2:    ch_sel = CH_STEER;
      default: ch_sel = CH_BATT;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    res_d    = res_q;
    cmd_d    = cmd_q;
    busy_d   = busy_q;
    wrt_d    = 1'b0;
    ld_vld_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (nxt) begin
          state_d = CNV;
          wrt_d   = 1'b1;
          cmd_d   = {2'b00, ch_sel, 11'h000};
          busy_d  = 1'b1;
          tmo_d   = '0;
        end
      end
      CNV: begin
        if (done) begin
          state_d = GAP;
          gap_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = RD;
          wrt_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      RD: begin
        if (done) begin
          state_d = STORE;
          data_d  = rd_data[11:0];
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      STORE: begin
        res_d[ptr_q] = data_q;
        ld_vld_d     = (ptr_q == 2'd1);
        busy_d       = 1'b0;
        ptr_d        = ptr_q + 2'd1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gap_q    <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
      res_q    <= '0;
      wrt_q    <= 1'b0;
      cmd_q    <= '0;
      busy_q   <= 1'b0;
      ld_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
      res_q    <= res_d;
      wrt_q    <= wrt_d;
      cmd_q    <= cmd_d;
      busy_q   <= busy_d;
      ld_vld_q <= ld_vld_d;
      err_q    <= err_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign busy      = busy_q;
  assign ld_vld    = ld_vld_q;
  assign err       = err_q;
  assign lft_ld    = res_q[0];
  assign rght_ld   = res_q[1];
  assign steer_pot = res_q[2];
  assign batt      = res_q[3];

endmodule

// File: tb/tb_a2d_rr_sampler.sv
// Directed bench for a2d_rr_sampler; the bench plays the SPI master by hand.
module tb_a2d_rr_sampler;

  logic        clk = 1'b0;
  logic        rst, nxt, done;
  logic [15:0] rd_data;
  logic        wrt, busy, ld_vld, err;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;

  int total = 0;
  int bad   = 0;
  int wrt_n = 0;
  int vld_n = 0;
  int err_n = 0;

  a2d_rr_sampler dut (
    .clk(clk), .rst(rst), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done),
    .rd_data(rd_data), .lft_ld(lft_ld), .rght_ld(rght_ld),
    .steer_pot(steer_pot), .batt(batt), .busy(busy), .ld_vld(ld_vld), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrt)    wrt_n++;
    if (ld_vld) vld_n++;
    if (err)    err_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_done(input logic [15:0] v);
    done = 1'b1; rd_data = v;
    @(negedge clk);
    done = 1'b0; rd_data = 16'h5A5A;
  endtask

  task automatic chk_rst();
    chk("rst_lft", lft_ld, 12'h000);
    chk("rst_rght", rght_ld, 12'h000);
    chk("rst_steer", steer_pot, 12'h000);
    chk("rst_batt", batt, 12'h000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wrt", wrt, 1'b0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_vld", ld_vld, 1'b0);
    chk("rst_err", err, 1'b0);
  endtask

  // Entered on the negedge where the convert wrt is visible; leaves on the
  // negedge where busy has dropped.
  task automatic run_xact(input logic [15:0] rsp, input logic [15:0] exp_cmd);
    int i;
    chk("wrt_cnv", wrt, 1'b1);
    chk("cmd_cnv", cmd, exp_cmd);
    chk("busy_hi", busy, 1'b1);
    repeat (3) @(negedge clk);
    pulse_done(16'hEEEE);
    i = 0;
    while (!wrt && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("wrt_rd", wrt, 1'b1);
    chk("gap_len", i, 4);
    chk("cmd_rd", cmd, exp_cmd);
    repeat (2) @(negedge clk);
    pulse_done(rsp);
    chk("busy_store", busy, 1'b1);
    i = 0;
    while (busy && i < 10) begin
      @(negedge clk);
      i++;
    end
    chk("busy_lo", busy, 1'b0);
  endtask

  initial begin
    int k, w0;
    rst = 1'b1; nxt = 1'b0; done = 1'b0; rd_data = 16'h5A5A;

    // reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_rst();

    // four channels in order
    @(negedge clk); nxt = 1'b1; @(negedge clk); nxt = 1'b0;
    run_xact(16'hF123, 16'h0000);
    chk("vld_after_lft", vld_n, 0);
    @(negedge clk); nxt = 1'b1; @(negedge clk); nxt = 1'b0;
    run_xact(16'h0456, 16'h2000);
    @(negedge clk); nxt = 1'b1; @(negedge clk); nxt = 1'b0;
    run_xact(16'h0789, 16'h2800);
    @(negedge clk); nxt = 1'b1; @(negedge clk); nxt = 1'b0;
    run_xact(16'h0ABC, 16'h3000);
    chk("t2_lft", lft_ld, 12'h123);
    chk("t2_rght", rght_ld, 12'h456);
    chk("t2_steer", steer_pot, 12'h789);
    chk("t2_batt", batt, 12'hABC);
    chk("t2_vld_n", vld_n, 1);

    // wrap back to lft
    @(negedge clk); nxt = 1'b1; @(negedge clk); nxt = 1'b0;
    run_xact(16'h7FED, 16'h0000);
    chk("t5_lft", lft_ld, 12'hFED);
    chk("t5_rght", rght_ld, 12'h456);
    chk("t5_steer", steer_pot, 12'h789);
    chk("t5_batt", batt, 12'hABC);
    chk("t5_vld_n", vld_n, 1);

    // nxt held high across two conversions
    repeat (2) @(negedge clk);
    w0 = wrt_n;
    nxt = 1'b1;
    @(negedge clk);
    run_xact(16'hA111, 16'h2000);
    @(negedge clk);
    run_xact(16'h0222, 16'h2800);
    nxt = 1'b0;
    repeat (5) @(negedge clk);
    chk("t3_wrt_n", wrt_n - w0, 4);
    chk("t3_busy", busy, 1'b0);
    chk("t3_rght", rght_ld, 12'h111);
    chk("t3_steer", steer_pot, 12'h222);
    chk("t3_vld_n", vld_n, 2);

    // done never arrives on batt
    @(negedge clk); nxt = 1'b1; @(negedge clk); nxt = 1'b0;
    chk("t4_cmd", cmd, 16'h3000);
    k = 0;
    while (!err && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("t4_tmo_cyc", k, 4096);
    chk("t4_busy", busy, 1'b0);
    chk("t4_batt", batt, 12'hABC);
    @(negedge clk);
    chk("t4_err_n", err_n, 1);
    nxt = 1'b1; @(negedge clk); nxt = 1'b0;
    run_xact(16'h0CDE, 16'h3000);
    chk("t4_batt_retry", batt, 12'hCDE);

    // reset mid-GAP on the lft channel
    @(negedge clk); nxt = 1'b1; @(negedge clk); nxt = 1'b0;
    chk("t6_cmd", cmd, 16'h0000);
    repeat (2) @(negedge clk);
    pulse_done(16'hEEEE);
    @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk_rst();
    w0 = wrt_n;
    @(negedge clk);
    pulse_done(16'h0999);
    repeat (10) @(negedge clk);
    chk("t6_stray_wrt", wrt_n - w0, 0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_lft", lft_ld, 12'h000);
    nxt = 1'b1; @(negedge clk); nxt = 1'b0;
    chk("t6_cmd_after", cmd, 16'h0000);
    chk("t6_wrt_after", wrt, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
